// File: rtl/fetch_ctrl_pkg.sv
// Shared types and encodings for the fetch controller and its latency counter.
package fetch_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StBootWr,
      StBootGap,
      StFetchAddr,
      StFetchWait,
      StFetchOut,
      StHalt
   } state_e;

   localparam logic [1:0] PhaseIdle  = 2'd0;
   localparam logic [1:0] PhaseBoot  = 2'd1;
   localparam logic [1:0] PhaseFetch = 2'd2;
   localparam logic [1:0] PhaseHalt  = 2'd3;

   localparam int unsigned DefaultWordStep = 4;

   function automatic logic [1:0] phase_of(state_e st);
      logic [1:0] ph;
      case (st)
         StBootWr, StBootGap:                 ph = PhaseBoot;
         StFetchAddr, StFetchWait, StFetchOut: ph = PhaseFetch;
         StHalt:                              ph = PhaseHalt;
         default:                             ph = PhaseIdle;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter that paces the memory read latency during instruction fetch.
module lat_counter #(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Boot-loader write sequencer followed by an instruction fetch loop over async-strobed memory.
// Optional boot word limit enabled by defining FETCH_CTRL_BOOT_LIMIT_EN.
module fetch_controller
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] BOOT_BASE      = 32'h0,
   parameter int unsigned WORD_STEP      = DefaultWordStep,
   parameter int unsigned MEM_LAT        = 1,
   parameter int unsigned BOOT_MAX_WORDS = 256
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        bootValid,
   input  logic        bootDone,
   output logic        bootReady,
   input  logic [31:0] pcAddress,
   input  logic        fetchStall,
   output logic [31:0] memAddress,
   output logic        memCS_n,
   output logic        memWE_n,
   output logic        memOE_n,
   output logic        enablePC,
   output logic        instrValid,
   output logic [1:0]  phase,
   output logic        bootOverflow
);

   if (MEM_LAT < 1 || MEM_LAT > 15 || BOOT_MAX_WORDS == 0) begin : g_param_err
      $error("fetch_controller: MEM_LAT must be 1..15 and BOOT_MAX_WORDS nonzero");
   end

   state_e      state_d, state_q;
   logic [31:0] boot_addr_d, boot_addr_q;
   logic [31:0] fetch_addr_d, fetch_addr_q;
   logic        done_d, done_q;
   logic        cnt_load, cnt_dec;
   logic [3:0]  cnt;
   logic        limit_hit;

   lat_counter #(
      .Width(4)
   ) u_lat_counter (
      .clk_i     (clock),
      .rst_ni    (reset_n),
      .load_i    (cnt_load),
      .load_val_i(4'(MEM_LAT - 1)),
      .dec_i     (cnt_dec),
      .count_o   (cnt)
   );

`ifdef FETCH_CTRL_BOOT_LIMIT_EN
   logic [31:0] word_cnt_q;
   logic        ovf_q;

   assign limit_hit = (word_cnt_q == 32'(BOOT_MAX_WORDS));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         word_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else if (state_q == StBootWr && bootValid) begin
         if (limit_hit) begin
            ovf_q <= 1'b1;
         end else begin
            word_cnt_q <= word_cnt_q + 32'd1;
         end
      end
   end

   assign bootOverflow = ovf_q;
`else
   assign limit_hit    = 1'b0;
   assign bootOverflow = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      boot_addr_d  = boot_addr_q;
      fetch_addr_d = fetch_addr_q;
      done_d       = done_q;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      memAddress   = 32'h0;
      memCS_n      = 1'b1;
      memWE_n      = 1'b1;
      memOE_n      = 1'b1;
      enablePC     = 1'b0;
      instrValid   = 1'b0;
      bootReady    = 1'b0;

      case (state_q)
         StIdle: state_d = StBootWr;
         StBootWr: begin
            bootReady  = 1'b1;
            memAddress = boot_addr_q;
            if (bootValid) begin
               if (limit_hit) begin
                  // Word past the limit is dropped without any strobe.
                  state_d = StHalt;
               end else begin
                  memCS_n = 1'b0;
                  memWE_n = 1'b0;
                  done_d  = bootDone;
                  state_d = StBootGap;
               end
            end else if (bootDone) begin
               state_d = StFetchAddr;
            end
         end
         StBootGap: begin
            memAddress  = boot_addr_q;
            boot_addr_d = boot_addr_q + 32'(WORD_STEP);
            done_d      = 1'b0;
            state_d     = (bootDone || done_q) ? StFetchAddr : StBootWr;
         end
         StFetchAddr: begin
            memAddress   = pcAddress;
            memCS_n      = 1'b0;
            memOE_n      = 1'b0;
            fetch_addr_d = pcAddress;
            cnt_load     = 1'b1;
            state_d      = (MEM_LAT <= 1) ? StFetchOut : StFetchWait;
         end
         StFetchWait: begin
            memAddress = fetch_addr_q;
            memCS_n    = 1'b0;
            memOE_n    = 1'b0;
            cnt_dec    = 1'b1;
            if (cnt <= 4'd1) begin
               state_d = StFetchOut;
            end
         end
         StFetchOut: begin
            memAddress = fetch_addr_q;
            memCS_n    = 1'b0;
            memOE_n    = 1'b0;
            instrValid = 1'b1;
            if (!fetchStall) begin
               enablePC = 1'b1;
               state_d  = StFetchAddr;
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         boot_addr_q  <= BOOT_BASE;
         fetch_addr_q <= 32'h0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         boot_addr_q  <= boot_addr_d;
         fetch_addr_q <= fetch_addr_d;
         done_q       <= done_d;
      end
   end

   assign phase = phase_of(state_q);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench: dut1 (base 0, MEM_LAT 3) covers boot/fetch/stall/reset; dut2 (base
// 0xFFFFFFFC, limit 2) covers address wrap and, with FETCH_CTRL_BOOT_LIMIT_EN, the limit.
module tb_fetch_controller;

   logic        clock;
   logic        reset_n;
   logic        bootValid;
   logic        bootDone;
   logic [31:0] pcAddress;
   logic        fetchStall;

   logic        d1_ready, d1_cs, d1_we, d1_oe, d1_epc, d1_iv, d1_ovf;
   logic [31:0] d1_addr;
   logic [1:0]  d1_phase;
   logic        d2_ready, d2_cs, d2_we, d2_oe, d2_epc, d2_iv, d2_ovf;
   logic [31:0] d2_addr;
   logic [1:0]  d2_phase;

   int checks;
   int errors;

   fetch_controller #(
      .BOOT_BASE     (32'h0),
      .WORD_STEP     (4),
      .MEM_LAT       (3),
      .BOOT_MAX_WORDS(256)
   ) dut1 (
      .clock       (clock),
      .reset_n     (reset_n),
      .bootValid   (bootValid),
      .bootDone    (bootDone),
      .bootReady   (d1_ready),
      .pcAddress   (pcAddress),
      .fetchStall  (fetchStall),
      .memAddress  (d1_addr),
      .memCS_n     (d1_cs),
      .memWE_n     (d1_we),
      .memOE_n     (d1_oe),
      .enablePC    (d1_epc),
      .instrValid  (d1_iv),
      .phase       (d1_phase),
      .bootOverflow(d1_ovf)
   );

   fetch_controller #(
      .BOOT_BASE     (32'hFFFF_FFFC),
      .WORD_STEP     (4),
      .MEM_LAT       (1),
      .BOOT_MAX_WORDS(2)
   ) dut2 (
      .clock       (clock),
      .reset_n     (reset_n),
      .bootValid   (bootValid),
      .bootDone    (bootDone),
      .bootReady   (d2_ready),
      .pcAddress   (pcAddress),
      .fetchStall  (fetchStall),
      .memAddress  (d2_addr),
      .memCS_n     (d2_cs),
      .memWE_n     (d2_we),
      .memOE_n     (d2_oe),
      .enablePC    (d2_epc),
      .instrValid  (d2_iv),
      .phase       (d2_phase),
      .bootOverflow(d2_ovf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset_n    = 1'b0;
      bootValid  = 1'b0;
      bootDone   = 1'b0;
      pcAddress  = 32'h40;
      fetchStall = 1'b0;

      tick();
      tick();
      chk("rst_phase", 32'(d1_phase), 32'd0);
      chk("rst_addr", d1_addr, 32'h0);
      chk("rst_cs", 32'(d1_cs), 32'd1);
      chk("rst_we", 32'(d1_we), 32'd1);
      chk("rst_oe", 32'(d1_oe), 32'd1);
      chk("rst_epc", 32'(d1_epc), 32'd0);
      chk("rst_iv", 32'(d1_iv), 32'd0);
      chk("rst_ready", 32'(d1_ready), 32'd0);
      chk("rst_ovf2", 32'(d2_ovf), 32'd0);

      reset_n = 1'b1;
      tick();
      chk("boot_phase", 32'(d1_phase), 32'd1);
      chk("boot_ready", 32'(d1_ready), 32'd1);
      chk("boot_idle_cs", 32'(d1_cs), 32'd1);

      // Word 0
      bootValid = 1'b1;
      #1;
      chk("w0_addr", d1_addr, 32'h0);
      chk("w0_we", 32'(d1_we), 32'd0);
      chk("w0_cs", 32'(d1_cs), 32'd0);
      chk("w0_oe", 32'(d1_oe), 32'd1);
      chk("w0_epc", 32'(d1_epc), 32'd0);
      chk("w0_addr2", d2_addr, 32'hFFFF_FFFC);
      chk("w0_we2", 32'(d2_we), 32'd0);
      tick();
      bootValid = 1'b0;
      #1;
      chk("gap0_we", 32'(d1_we), 32'd1);
      chk("gap0_phase", 32'(d1_phase), 32'd1);
      chk("gap0_epc", 32'(d1_epc), 32'd0);

      // Word 1
      tick();
      bootValid = 1'b1;
      #1;
      chk("w1_addr", d1_addr, 32'h4);
      chk("w1_we", 32'(d1_we), 32'd0);
      chk("w1_wrap_addr2", d2_addr, 32'h0);
      chk("w1_we2", 32'(d2_we), 32'd0);
      tick();
      bootValid = 1'b0;
      tick();

      // Word 2
      bootValid = 1'b1;
      #1;
      chk("w2_addr", d1_addr, 32'h8);
      chk("w2_we", 32'(d1_we), 32'd0);
`ifdef FETCH_CTRL_BOOT_LIMIT_EN
      chk("lim_no_we2", 32'(d2_we), 32'd1);
      chk("lim_no_cs2", 32'(d2_cs), 32'd1);
`else
      chk("w2_addr2", d2_addr, 32'h4);
      chk("w2_we2", 32'(d2_we), 32'd0);
`endif
      tick();
      bootValid = 1'b0;
      bootDone  = 1'b1;
      #1;
      chk("gap2_we", 32'(d1_we), 32'd1);
      chk("gap2_phase", 32'(d1_phase), 32'd1);
`ifdef FETCH_CTRL_BOOT_LIMIT_EN
      chk("lim_ovf2", 32'(d2_ovf), 32'd1);
      chk("lim_phase2", 32'(d2_phase), 32'd3);
      chk("lim_halt_cs2", 32'(d2_cs), 32'd1);
`else
      chk("nolim_ovf2", 32'(d2_ovf), 32'd0);
      chk("nolim_phase2", 32'(d2_phase), 32'd1);
`endif

      // First fetch right after the last gap
      tick();
      bootDone = 1'b0;
      #1;
      chk("fa_phase", 32'(d1_phase), 32'd2);
      chk("fa_addr", d1_addr, 32'h40);
      chk("fa_cs", 32'(d1_cs), 32'd0);
      chk("fa_oe", 32'(d1_oe), 32'd0);
      chk("fa_we", 32'(d1_we), 32'd1);
      chk("fa_iv", 32'(d1_iv), 32'd0);
      tick();
      chk("fw1_iv", 32'(d1_iv), 32'd0);
      chk("fw1_oe", 32'(d1_oe), 32'd0);
      chk("fw1_addr", d1_addr, 32'h40);
      tick();
      chk("fw2_iv", 32'(d1_iv), 32'd0);
      tick();
      chk("fo_iv", 32'(d1_iv), 32'd1);
      chk("fo_epc", 32'(d1_epc), 32'd1);
      tick();
      chk("fa2_epc", 32'(d1_epc), 32'd0);
      chk("fa2_iv", 32'(d1_iv), 32'd0);
      chk("fa2_addr", d1_addr, 32'h40);

      // Stall in FETCH_OUT for 5 cycles
      fetchStall = 1'b1;
      tick();
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("stall_iv", 32'(d1_iv), 32'd1);
         chk("stall_epc", 32'(d1_epc), 32'd0);
         chk("stall_oe", 32'(d1_oe), 32'd0);
         tick();
      end
      fetchStall = 1'b0;
      #1;
      chk("rel_epc", 32'(d1_epc), 32'd1);
      chk("rel_iv", 32'(d1_iv), 32'd1);
      tick();
      chk("rel_next_epc", 32'(d1_epc), 32'd0);
      chk("rel_next_phase", 32'(d1_phase), 32'd2);

      // Reset in the middle of a boot write
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      bootValid = 1'b1;
      tick();
      bootValid = 1'b0;
      tick();
      bootValid = 1'b1;
      #1;
      chk("mw_addr", d1_addr, 32'h4);
      chk("mw_we", 32'(d1_we), 32'd0);
      reset_n = 1'b0;
      #1;
      chk("mw_rst_we", 32'(d1_we), 32'd1);
      chk("mw_rst_cs", 32'(d1_cs), 32'd1);
      chk("mw_rst_oe", 32'(d1_oe), 32'd1);
      chk("mw_rst_phase", 32'(d1_phase), 32'd0);
      chk("mw_rst_addr", d1_addr, 32'h0);
      chk("mw_rst_ovf2", 32'(d2_ovf), 32'd0);
      bootValid = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();

      // Valid and done together: write first, then fetch
      bootValid = 1'b1;
      bootDone  = 1'b1;
      #1;
      chk("vd_addr", d1_addr, 32'h0);
      chk("vd_we", 32'(d1_we), 32'd0);
      tick();
      bootValid = 1'b0;
      bootDone  = 1'b0;
      #1;
      chk("vd_gap_we", 32'(d1_we), 32'd1);
      chk("vd_gap_phase", 32'(d1_phase), 32'd1);
      tick();
      chk("vd_fetch_phase", 32'(d1_phase), 32'd2);
      chk("vd_fetch_oe", 32'(d1_oe), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
